bus_timer: RTL
==============

// Module: bus_timer
// PURPOSE
//   Memory-mapped machine timer that answers the CPU data-bus master port (WE/ADR/DAT).
//   Holds a 64-bit free-running MTIME counter, a 64-bit MTIMECMP compare register and a
//   prescaler. Drives INT_O, which connects to the CPU INT_I when MTIME >= MTIMECMP.
//   Sits on the data bus beside data memory, selected by an address window.
// PARAMETERS
//   BASE_ADDR  32'h00010000  window base; ADR_I[31:5]==BASE_ADDR[31:5] selects the block
//   PRESC_W    8             prescaler width in bits (CTRL.PRESCALE field width)
// PORTS
//   CLK_I   in   1   single system clock, rising edge
//   RST_I   in   1   asynchronous, active-low reset
//   WE_I    in   1   write enable from CPU (level, one write per cycle)
//   ADR_I   in   32  byte address from CPU; bits [1:0] ignored
//   DAT_I   in   32  write data from CPU
//   DAT_O   out  32  read data to CPU (combinational)
//   INT_O   out  1   timer interrupt request to CPU INT_I (registered, level)
// BEHAVIOUR
//   Register map (word offsets, ADR_I[4:2]):
//     0x00 MTIME_LO    RW   0x04 MTIME_HI    RW
//     0x08 MTIMECMP_LO RW   0x0C MTIMECMP_HI RW
//     0x10 CTRL  RW: [0] EN, [1] IE, [8+PRESC_W-1:8] PRESCALE; all other bits read 0
//     0x14 STATUS: [0] PEND RO (=MTIME>=MTIMECMP, unsigned 64-bit); [1] WRAP sticky, W1C
//     0x18,0x1C unmapped: read 0, writes ignored
//   Reset (RST_I=0, async): MTIME=0, MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, WRAP=0,
//     prescaler count=0, INT_O=0. DAT_O follows its combinational rule during reset.
//   Reads: no read strobe exists, so reads are combinational and side-effect free;
//     DAT_O=0 when window not selected or offset unmapped. Zero-cycle read latency.
//   Writes: full 32-bit word only, take effect at the rising edge where WE_I=1 & selected.
//   Prescaler: count runs only when EN=1; tick asserted when count==PRESCALE, then count
//     returns to 0. PRESCALE=0 -> MTIME increments every cycle; N -> every N+1 cycles.
//     EN=0 holds count and MTIME. Any CTRL or MTIME_LO/HI write clears count to 0.
//   MTIME: on tick, MTIME<=MTIME+1 (64-bit, carry LO->HI). At 64'hFFFF..FF +1 -> 0, set WRAP.
//     A write to MTIME_LO/HI in the same cycle as a tick wins: written half takes DAT_I,
//     other half holds (no increment applied that cycle).
//   WRAP: writing STATUS with DAT_I[1]=1 clears it; a wrap in the same cycle wins (stays 1).
//   Interrupt: INT_O<=IE & PEND each cycle (1-cycle latency from compare, PEND from
//     current registers). EN does not gate INT_O. Level-held until software raises
//     MTIMECMP above MTIME or clears IE; INT_O drops the cycle after that write.
//   Software reads 64-bit MTIME as HI,LO,HI and retries on HI mismatch; no shadow latch.
//   Reset deasserted mid-count: counting restarts from reset values, no partial state.
// STRUCTURE
//   Offsets (TMR_MTIME_LO..TMR_STATUS), CTRL bit positions and MTIMECMP reset value go in
//   the shared general_definitions.vh header so firmware headers and benches share them.
//   One sub-module: timer_prescaler (EN, PRESCALE, clear -> tick), PRESC_W-wide counter.
//   Top holds decode, 64-bit counter, compare, STATUS/CTRL regs, read mux, INT_O flop.
// TESTING
//   1 Reset: RST_I=0 mid-run -> MTIME=0, CTRL=0, MTIMECMP_LO/HI read 0xFFFFFFFF, INT_O=0.
//   2 Prescale: CTRL=0x0301 (EN, PRESCALE=3), 40 cycles -> MTIME_LO=10; PRESCALE=0 -> +1/cycle.
//   3 Carry/wrap: write MTIME_HI=0xFFFFFFFF, LO=0xFFFFFFFE, EN, PRESC 0 -> after 2 ticks
//     MTIME=0, STATUS=0x2; W1C write 0x2 -> 0; W1C coincident with wrap -> WRAP stays 1.
//   4 Interrupt: MTIMECMP=0x0000_0000_0000_0010, CTRL=0x3, PRESC 0 -> PEND at MTIME=0x10,
//     INT_O high one cycle later; write MTIMECMP_LO=0x100 -> INT_O low next cycle; IE=0 -> low.
//   5 Write vs tick: write MTIME_LO=0x55 on a tick cycle -> MTIME_LO reads 0x55, HI unchanged,
//     prescaler count restarts (next increment PRESCALE+1 cycles later).
//   6 Decode: ADR_I outside window or offset 0x18 -> DAT_O=0, writes leave all regs unchanged;
//     ADR_I=BASE+0x13 reads CTRL (byte bits ignored).

Source files
------------

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// CTRL/STATUS bit positions, the MTIMECMP reset value and the address-window decode.
package bus_timer_pkg;

  localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
  localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL        = 3'd4;
  localparam logic [2:0] TMR_STATUS      = 3'd5;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IE_BIT     = 1;
  localparam int CTRL_PRESC_LSB  = 8;
  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_WRAP_BIT = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // The block owns a 32-byte window; only the bits above the word offset are compared.
  function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:5] == base[31:5];
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// CPU data-bus connection for the timer: write strobe, address, data both ways, interrupt.
// Handshake: no valid/ready pair exists; a write is accepted on every rising edge where
// WE_I=1 and the address hits the window, and reads are combinational with no strobe.
interface bus_timer_if;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        INT_O;

  modport master (output WE_I, ADR_I, DAT_I, input DAT_O, INT_O);
  modport slave  (input WE_I, ADR_I, DAT_I, output DAT_O, INT_O);
endinterface

// File: rtl/bus_timer_prescaler.sv
// Divides the clock by PRESCALE+1 while enabled; tick marks the cycle on which
// MTIME advances.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               clear,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  assign tick = en && (count == prescale);

  // A clear restarts the period even if this cycle also ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (tick) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Machine timer: 64-bit MTIME with prescaler, 64-bit MTIMECMP, CTRL/STATUS registers,
// combinational read mux and a registered level interrupt.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          PRESC_W   = 8
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  bus_timer_if.slave bus
);

  logic               sel;
  logic               wr;
  logic [2:0]         off;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               en;
  logic               ie;
  logic [PRESC_W-1:0] prescale;
  logic               wrap;
  logic               int_q;
  logic               tick;
  logic               pend;
  logic               mtime_wr;
  logic               presc_clear;
  logic [31:0]        rdata;
  logic               unused_adr;

  assign sel         = in_window(bus.ADR_I, BASE_ADDR);
  assign off         = bus.ADR_I[4:2];
  assign wr          = bus.WE_I & sel;
  assign mtime_wr    = wr & ((off == TMR_MTIME_LO) | (off == TMR_MTIME_HI));
  assign presc_clear = mtime_wr | (wr & (off == TMR_CTRL));
  assign pend        = mtime >= mtimecmp;
  assign unused_adr  = ^bus.ADR_I[1:0];

  timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk      (CLK_I),
    .rst_n    (RST_I),
    .en       (en),
    .prescale (prescale),
    .clear    (presc_clear),
    .tick     (tick)
  );

  // A software write to either MTIME half suppresses that cycle's increment.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      mtime <= '0;
    end else if (wr && off == TMR_MTIME_LO) begin
      mtime[31:0] <= bus.DAT_I;
    end else if (wr && off == TMR_MTIME_HI) begin
      mtime[63:32] <= bus.DAT_I;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      mtimecmp <= MTIMECMP_RST;
      en       <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
    end else if (wr) begin
      if (off == TMR_MTIMECMP_LO) mtimecmp[31:0]  <= bus.DAT_I;
      if (off == TMR_MTIMECMP_HI) mtimecmp[63:32] <= bus.DAT_I;
      if (off == TMR_CTRL) begin
        en       <= bus.DAT_I[CTRL_EN_BIT];
        ie       <= bus.DAT_I[CTRL_IE_BIT];
        prescale <= bus.DAT_I[CTRL_PRESC_LSB +: PRESC_W];
      end
    end
  end

  // A wrap landing in the same cycle as the W1C clear keeps the flag set.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wrap <= 1'b0;
    end else if (tick && !mtime_wr && (&mtime)) begin
      wrap <= 1'b1;
    end else if (wr && off == TMR_STATUS && bus.DAT_I[STATUS_WRAP_BIT]) begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) int_q <= 1'b0;
    else        int_q <= ie & pend;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        TMR_MTIME_LO:    rdata = mtime[31:0];
        TMR_MTIME_HI:    rdata = mtime[63:32];
        TMR_MTIMECMP_LO: rdata = mtimecmp[31:0];
        TMR_MTIMECMP_HI: rdata = mtimecmp[63:32];
        TMR_CTRL: begin
          rdata[CTRL_EN_BIT]                   = en;
          rdata[CTRL_IE_BIT]                   = ie;
          rdata[CTRL_PRESC_LSB +: PRESC_W]     = prescale;
        end
        TMR_STATUS: begin
          rdata[STATUS_PEND_BIT] = pend;
          rdata[STATUS_WRAP_BIT] = wrap;
        end
        default:         rdata = '0;
      endcase
    end
  end

  assign bus.DAT_O = rdata;
  assign bus.INT_O = int_q;

endmodule
